store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_pkg.sv | 17 +
 rtl/store_buffer_if.sv | 36 +++
 rtl/sb_fifo.sv | 43 ++++
 rtl/store_buffer.sv | 91 +++++++++
 tb/tb_store_buffer.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/store_pkg.sv
// Shared types for the store buffer: default depth, FSM states
// and the pending-store entry layout.
package store_pkg;

  localparam int SB_DEPTH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Store-stage, data-memory and forwarding signals of the store buffer.
// The slave modport is the buffer; the master is its environment.
interface store_buffer_if;

  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;

  logic [31:0] ld_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;

  logic        empty;
  logic        err;

  modport slave (
    input  st_valid, st_addr, st_data,
    input  mem_ack, ld_addr,
    output st_ready, mem_req, mem_addr, mem_wdata,
    output fwd_hit, fwd_data, empty, err
  );

  modport master (
    output st_valid, st_addr, st_data,
    output mem_ack, ld_addr,
    input  st_ready, mem_req, mem_addr, mem_wdata,
    input  fwd_hit, fwd_data, empty, err
  );

endinterface

// File: rtl/sb_fifo.sv
// Pending-store FIFO: storage, wrap-around pointers and occupancy.
// Slots are exposed so the owner can search them for forwarding.
module sb_fifo
  import store_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  entry_t                   entry,
  output entry_t                   head,
  output entry_t [DEPTH-1:0]       slots,
  output logic [$clog2(DEPTH)-1:0] rd_ptr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Payload needs no reset: count gates every use of it.
  always_ff @(posedge clk) begin
    if (push) slots[wr_ptr] <= entry;
  end

  assign head = slots[rd_ptr];

endmodule

// File: rtl/store_buffer.sv
// Store buffer: in-order write queue toward data memory with
// combinational youngest-match store-to-load forwarding.
module store_buffer
  import store_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input logic           clk,
  input logic           reset,
  store_buffer_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  state_t             state;
  state_t             state_nx;
  entry_t             head;
  entry_t             wr_entry;
  entry_t [DEPTH-1:0] slots;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic               hs;
  logic               aligned;
  logic               push;
  logic               pop;
  logic               busy;
  logic               err_q;

  assign busy         = (state == BUSY);
  assign aligned      = (bus.st_addr[1:0] == 2'b00);
  assign bus.st_ready = (count != CW'(DEPTH));
  assign hs           = bus.st_valid & bus.st_ready;
  assign push         = hs & aligned;
  assign pop          = busy & bus.mem_ack;

  assign wr_entry.addr = bus.st_addr;
  assign wr_entry.data = bus.st_data;

  sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .pop    (pop),
    .entry  (wr_entry),
    .head   (head),
    .slots  (slots),
    .rd_ptr (rd_ptr),
    .count  (count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (count != '0 || push) state_nx = BUSY;
      BUSY: if (pop && count == CW'(1) && !push) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.mem_req   = busy;
  assign bus.mem_addr  = busy ? head.addr : '0;
  assign bus.mem_wdata = busy ? head.data : '0;
  assign bus.empty     = (count == '0) & ~busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             err_q <= 1'b0;
    else if (hs & ~aligned) err_q <= 1'b1;
  end

  assign bus.err = err_q;

  // Walk oldest to youngest so the last match is the youngest.
  always_comb begin
    bus.fwd_hit  = 1'b0;
    bus.fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count &&
          slots[rd_ptr + PW'(i)].addr[31:2] == bus.ld_addr[31:2]) begin
        bus.fwd_hit  = 1'b1;
        bus.fwd_data = slots[rd_ptr + PW'(i)].data;
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: a queue model checked every
// cycle, plus literal expectations for each scenario.
module tb_store_buffer;
  import store_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;

  store_buffer_if bus ();

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int     vectors = 0;
  int     miscompares = 0;
  bit     cmp_on = 1'b0;
  entry_t q[$];
  entry_t wlog[$];
  entry_t m_ent;
  entry_t w_ent;
  bit     m_err = 1'b0;
  bit     m_rdy;
  logic        e_hit;
  logic [31:0] e_data;
  int     nlog;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.st_valid = 1'b1;
    bus.st_addr  = a;
    bus.st_data  = d;
  endtask

  task automatic drain();
    bus.st_valid = 1'b0;
    bus.mem_ack  = 1'b1;
    for (int n = 0; n < 20 && !bus.empty; n++) cyc();
    chk("drain_empty", 32'(bus.empty), 32'd1);
    bus.mem_ack = 1'b0;
  endtask

  function automatic void model_fwd(input logic [31:0] a,
                                    output logic h,
                                    output logic [31:0] d);
    h = 1'b0;
    d = '0;
    foreach (q[i]) begin
      if (q[i].addr[31:2] == a[31:2]) begin
        h = 1'b1;
        d = q[i].data;
      end
    end
  endfunction

  // Model: queue of pending stores; memory is busy whenever any remain.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      m_err = 1'b0;
    end else begin
      m_rdy = (q.size() != DEPTH);
      if (bus.st_valid && m_rdy && bus.st_addr[1:0] != 2'b00) m_err = 1'b1;
      if (q.size() != 0 && bus.mem_ack) void'(q.pop_front());
      if (bus.st_valid && m_rdy && bus.st_addr[1:0] == 2'b00) begin
        m_ent.addr = bus.st_addr;
        m_ent.data = bus.st_data;
        q.push_back(m_ent);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      model_fwd(bus.ld_addr, e_hit, e_data);
      chk("st_ready", 32'(bus.st_ready), 32'(q.size() != DEPTH));
      chk("mem_req", 32'(bus.mem_req), 32'(q.size() != 0));
      chk("mem_addr", bus.mem_addr, q.size() != 0 ? q[0].addr : 32'd0);
      chk("mem_wdata", bus.mem_wdata, q.size() != 0 ? q[0].data : 32'd0);
      chk("fwd_hit", 32'(bus.fwd_hit), 32'(e_hit));
      chk("fwd_data", bus.fwd_data, e_data);
      chk("empty", 32'(bus.empty), 32'(q.size() == 0));
      chk("err", 32'(bus.err), 32'(m_err));
    end
  end

  always @(negedge clk) begin
    if (reset && bus.mem_req && bus.mem_ack) begin
      w_ent.addr = bus.mem_addr;
      w_ent.data = bus.mem_wdata;
      wlog.push_back(w_ent);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.st_valid = 1'b0;
    bus.st_addr  = '0;
    bus.st_data  = '0;
    bus.mem_ack  = 1'b0;
    bus.ld_addr  = '0;
    reset = 1'b0;
    repeat (2) cyc();
    @(negedge clk);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_fwd_hit", 32'(bus.fwd_hit), 32'd0);
    cmp_on = 1'b1;
    cyc();
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(bus.st_ready), 32'd1);

    // single store
    cyc();
    store(32'h100, 32'hDEADBEEF);
    cyc();
    bus.st_valid = 1'b0;
    @(negedge clk);
    chk("single_req", 32'(bus.mem_req), 32'd1);
    chk("single_addr", bus.mem_addr, 32'h100);
    chk("single_data", bus.mem_wdata, 32'hDEADBEEF);
    cyc();
    cyc();
    bus.mem_ack = 1'b1;
    @(negedge clk);
    chk("single_hold", bus.mem_addr, 32'h100);
    cyc();
    bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("single_empty", 32'(bus.empty), 32'd1);
    chk("single_idle", 32'(bus.mem_req), 32'd0);

    // fill and stall
    wlog.delete();
    for (int k = 1; k <= 4; k++) begin
      cyc();
      store(32'h300 + 32'(4 * k), 32'(k));
    end
    cyc();
    store(32'h314, 32'd5);
    @(negedge clk);
    chk("full_ready", 32'(bus.st_ready), 32'd0);
    cyc();
    bus.mem_ack = 1'b1;
    @(negedge clk);
    chk("no_bypass", 32'(bus.st_ready), 32'd0);
    cyc();
    bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("ready_after_pop", 32'(bus.st_ready), 32'd1);
    cyc();
    drain();
    chk("order_count", 32'(wlog.size()), 32'd5);
    for (int k = 0; k < 5 && k < wlog.size(); k++) begin
      chk("order_data", wlog[k].data, 32'(k + 1));
      chk("order_addr", wlog[k].addr, 32'h304 + 32'(4 * k));
    end

    // forwarding
    cyc();
    store(32'h200, 32'h11);
    cyc();
    store(32'h200, 32'h22);
    cyc();
    store(32'h208, 32'h33);
    bus.ld_addr = 32'h202;
    @(negedge clk);
    chk("fwd_young_hit", 32'(bus.fwd_hit), 32'd1);
    chk("fwd_young_data", bus.fwd_data, 32'h22);
    bus.ld_addr = 32'h208;
    #1;
    chk("fwd_same_cycle", 32'(bus.fwd_hit), 32'd0);
    bus.ld_addr = 32'h204;
    #1;
    chk("fwd_miss_hit", 32'(bus.fwd_hit), 32'd0);
    chk("fwd_miss_data", bus.fwd_data, 32'd0);
    cyc();
    bus.st_valid = 1'b0;
    bus.ld_addr = 32'h20B;
    @(negedge clk);
    chk("fwd_late_data", bus.fwd_data, 32'h33);
    cyc();
    drain();
    bus.ld_addr = 32'h0;

    // misaligned
    cyc();
    store(32'h101, 32'h55);
    cyc();
    bus.st_valid = 1'b0;
    @(negedge clk);
    chk("mis_err", 32'(bus.err), 32'd1);
    chk("mis_no_req", 32'(bus.mem_req), 32'd0);
    cyc();
    store(32'h400, 32'h66);
    cyc();
    drain();
    chk("mis_sticky", 32'(bus.err), 32'd1);

    // reset mid-operation
    cyc();
    store(32'h500, 32'h1);
    cyc();
    store(32'h504, 32'h2);
    cyc();
    store(32'h508, 32'h3);
    cyc();
    bus.st_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_req", 32'(bus.mem_req), 32'd1);
    cyc();
    #2;
    reset = 1'b0;
    bus.ld_addr = 32'h504;
    #1;
    chk("async_req", 32'(bus.mem_req), 32'd0);
    chk("async_empty", 32'(bus.empty), 32'd1);
    chk("async_fwd", 32'(bus.fwd_hit), 32'd0);
    chk("async_err", 32'(bus.err), 32'd0);
    repeat (2) cyc();
    reset = 1'b1;
    nlog = wlog.size();
    bus.mem_ack = 1'b1;
    repeat (5) cyc();
    chk("no_writes_after", 32'(wlog.size()), 32'(nlog));
    bus.mem_ack = 1'b0;
    bus.ld_addr = 32'h0;

    // streaming
    wlog.delete();
    bus.mem_ack = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      store(32'h600 + 32'(4 * k), 32'h1000 + 32'(k));
      @(negedge clk);
      chk("stream_ready", 32'(bus.st_ready), 32'd1);
      if (k > 0) chk("stream_addr", bus.mem_addr, 32'h600 + 32'(4 * (k - 1)));
    end
    cyc();
    bus.st_valid = 1'b0;
    @(negedge clk);
    chk("stream_last", bus.mem_addr, 32'h61C);
    cyc();
    @(negedge clk);
    chk("stream_empty", 32'(bus.empty), 32'd1);
    bus.mem_ack = 1'b0;
    chk("stream_count", 32'(wlog.size()), 32'd8);

    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
